// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard interlock.
package hazard_pkg;

    localparam int unsigned REG_W     = 5;
    localparam logic [1:0]  STALL_MAX = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } stallState_e;

endpackage

// File: rtl/reg_match.sv
// Register-number compare that never reports a hit against $0.
module reg_match
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] wReg,
    input  logic [REG_W-1:0] rReg,
    output logic             hit
);

    assign hit = (wReg != '0) && (wReg == rReg);

endmodule

// File: rtl/hazard_stall_unit.sv
// Load-use / ID-branch interlock with data-memory wait freeze.
// Optional HAZ_PERF_CNT_EN adds saturating stall and freeze cycle counters.
module hazard_stall_unit
    import hazard_pkg::*;
`ifdef HAZ_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 16
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ID_rs,
    input  logic [REG_W-1:0] ID_rt,
    input  logic             ID_UseRt,
    input  logic             ID_Branch,
    input  logic             EX_MemRead,
    input  logic             EX_RegWrite,
    input  logic [REG_W-1:0] EX_WriteRegister,
    input  logic             MEM_MemRead,
    input  logic [REG_W-1:0] MEM_WriteRegister,
    input  logic             MEM_Wait,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             ID_Bubble,
    output logic             Freeze,
    output logic             Stalling
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FreezeCycles
`endif
);

    logic exRsHit, exRtHit, memRsHit, memRtHit;
    logic exHit, memHit;
    logic [1:0] need;
    logic [1:0] rem, remNext;
    stallState_e state, stateNext;
    logic stall, freeze;

    reg_match uExRs  (.wReg(EX_WriteRegister),  .rReg(ID_rs), .hit(exRsHit));
    reg_match uExRt  (.wReg(EX_WriteRegister),  .rReg(ID_rt), .hit(exRtHit));
    reg_match uMemRs (.wReg(MEM_WriteRegister), .rReg(ID_rs), .hit(memRsHit));
    reg_match uMemRt (.wReg(MEM_WriteRegister), .rReg(ID_rt), .hit(memRtHit));

    assign exHit  = exRsHit  || (ID_UseRt && exRtHit);
    assign memHit = memRsHit || (ID_UseRt && memRtHit);

    always_comb begin
        need = 2'd0;
        if (ID_Branch && EX_MemRead && exHit)
            need = STALL_MAX;
        else if (EX_MemRead && exHit)
            need = 2'd1;
        else if (ID_Branch && EX_RegWrite && exHit)
            need = 2'd1;
        else if (ID_Branch && MEM_MemRead && memHit)
            need = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rem   <= '0;
        end else begin
            state <= stateNext;
            rem   <= remNext;
        end
    end

    // Memory wait outranks everything: FSM and rem simply hold while it is high.
    always_comb begin
        stateNext = state;
        remNext   = rem;
        stall     = 1'b0;
        freeze    = 1'b0;
        if (!reset) begin
            if (MEM_Wait) begin
                freeze = 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (need != 2'd0) begin
                            stall   = 1'b1;
                            remNext = need - 2'd1;
                            if (need == STALL_MAX)
                                stateNext = HOLD;
                        end
                    end
                    HOLD: begin
                        stall   = 1'b1;
                        remNext = rem - 2'd1;
                        if (rem == 2'd1)
                            stateNext = IDLE;
                    end
                    default: stateNext = IDLE;
                endcase
            end
        end
    end

    assign PC_Write   = !(stall || freeze);
    assign IFID_Write = !(stall || freeze);
    assign ID_Bubble  = stall;
    assign Freeze     = freeze;
    assign Stalling   = (state == HOLD);

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            StallCycles  <= '0;
            FreezeCycles <= '0;
        end else begin
            if (ID_Bubble && (StallCycles != '1))
                StallCycles <= StallCycles + 1'b1;
            if (Freeze && (FreezeCycles != '1))
                FreezeCycles <= FreezeCycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: driver queues expected outputs, monitor checks them.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] ID_rs, ID_rt, EX_WriteRegister, MEM_WriteRegister;
  logic       ID_UseRt, ID_Branch, EX_MemRead, EX_RegWrite, MEM_MemRead, MEM_Wait;
  logic       PC_Write, IFID_Write, ID_Bubble, Freeze, Stalling;
`ifdef HAZ_PERF_CNT_EN
  logic [3:0] StallCycles, FreezeCycles;
`endif

`ifdef HAZ_PERF_CNT_EN
  hazard_stall_unit #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRt(ID_UseRt), .ID_Branch(ID_Branch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteRegister(EX_WriteRegister),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteRegister(MEM_WriteRegister), .MEM_Wait(MEM_Wait),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .ID_Bubble(ID_Bubble),
    .Freeze(Freeze), .Stalling(Stalling),
    .StallCycles(StallCycles), .FreezeCycles(FreezeCycles)
  );
`else
  hazard_stall_unit dut (
    .clk(clk), .reset(reset),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_UseRt(ID_UseRt), .ID_Branch(ID_Branch),
    .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite), .EX_WriteRegister(EX_WriteRegister),
    .MEM_MemRead(MEM_MemRead), .MEM_WriteRegister(MEM_WriteRegister), .MEM_Wait(MEM_Wait),
    .PC_Write(PC_Write), .IFID_Write(IFID_Write), .ID_Bubble(ID_Bubble),
    .Freeze(Freeze), .Stalling(Stalling)
  );
`endif

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       useRt, br, exMR, exRW;
    logic [4:0] exWR;
    logic       memMR;
    logic [4:0] memWR;
    logic       wt;
  } vec_t;

  typedef struct {
    string      nm;
    logic [4:0] v;
  } exp_t;

  vec_t v;
  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  task automatic clr();
    v = '0;
  endtask

  task automatic step(input string nm, input bit chk, input logic [3:0] e);
    @(negedge clk);
    reset             = v.rst;
    ID_rs             = v.rs;
    ID_rt             = v.rt;
    ID_UseRt          = v.useRt;
    ID_Branch         = v.br;
    EX_MemRead        = v.exMR;
    EX_RegWrite       = v.exRW;
    EX_WriteRegister  = v.exWR;
    MEM_MemRead       = v.memMR;
    MEM_WriteRegister = v.memWR;
    MEM_Wait          = v.wt;
    if (chk) q.push_back('{nm, {e[3], e[3], e[2:0]}});
  endtask

  initial begin : monitor
    exp_t       e;
    logic [4:0] act;
    forever begin
      @(negedge clk);
      #4;
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {PC_Write, IFID_Write, ID_Bubble, Freeze, Stalling};
        tests++;
        if (act !== e.v) begin
          failed++;
          $display("FAIL %s: got pc/ifid/bub/frz/stl=%b expected %b", e.nm, act, e.v);
        end
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  task automatic chkCnt(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
`endif

  initial begin : driver
    clr(); v.rst = 1'b1;
    step("rst0", 0, 4'b1000);
    step("reset", 1, 4'b1000);

    clr(); v.rs = 5'd8; v.exMR = 1; v.exRW = 1; v.exWR = 5'd8;
    step("lu_stall", 1, 4'b0100);
    v.exMR = 0; v.exRW = 0; v.memMR = 1; v.memWR = 5'd8;
    step("lu_release", 1, 4'b1000);

    clr(); v.br = 1; v.rs = 5'd3; v.rt = 5'd9; v.useRt = 1; v.exMR = 1; v.exRW = 1; v.exWR = 5'd9;
    step("br_ld_c1", 1, 4'b0100);
    clr();
    step("br_ld_c2", 1, 4'b0101);
    clr(); v.br = 1; v.rs = 5'd3; v.rt = 5'd9; v.useRt = 1; v.memWR = 5'd9;
    step("br_ld_c3", 1, 4'b1000);

    clr(); v.exMR = 1; v.exRW = 1;
    step("ld_r0", 1, 4'b1000);
    clr(); v.rs = 5'd1; v.rt = 5'd5; v.exMR = 1; v.exWR = 5'd5;
    step("rt_unused", 1, 4'b1000);
    v.useRt = 1;
    step("rt_used", 1, 4'b0100);

    clr(); v.br = 1; v.rs = 5'd4; v.exRW = 1; v.exWR = 5'd4;
    step("br_alu_ex", 1, 4'b0100);
    clr(); v.br = 1; v.rt = 5'd6; v.useRt = 1; v.memMR = 1; v.memWR = 5'd6;
    step("br_ld_mem", 1, 4'b0100);
    v.br = 0;
    step("add_ld_mem", 1, 4'b1000);

    clr(); v.br = 1; v.rs = 5'd7; v.exMR = 1; v.exRW = 1; v.exWR = 5'd7;
    step("w_c1", 1, 4'b0100);
    clr(); v.wt = 1;
    repeat (3) step("w_frz", 1, 4'b0011);
    clr();
    step("w_hold", 1, 4'b0101);
    step("w_rel", 1, 4'b1000);

    clr(); v.rs = 5'd2; v.exMR = 1; v.exWR = 5'd2; v.wt = 1;
    step("wi_frz", 1, 4'b0010);
    v.wt = 0;
    step("wi_stall", 1, 4'b0100);
    clr();
    step("wi_rel", 1, 4'b1000);

    clr(); v.br = 1; v.rt = 5'd3; v.useRt = 1; v.exMR = 1; v.exWR = 5'd3;
    step("r_c1", 1, 4'b0100);
    clr(); v.rst = 1;
    step("r_rst", 1, 4'b1001);
    clr();
    step("r_idle", 1, 4'b1000);

`ifdef HAZ_PERF_CNT_EN
    chkCnt("stall_cnt_clr", StallCycles, 4'h0);
    chkCnt("frz_cnt_clr", FreezeCycles, 4'h0);
    clr(); v.rs = 5'd10; v.exMR = 1; v.exWR = 5'd10;
    repeat (20) step("cnt_lu", 1, 4'b0100);
    clr();
    step("cnt_idle", 1, 4'b1000);
    chkCnt("stall_cnt_sat", StallCycles, 4'hF);
    clr(); v.wt = 1;
    repeat (2) step("cnt_frz", 1, 4'b0010);
    clr();
    step("cnt_idle2", 1, 4'b1000);
    chkCnt("frz_cnt", FreezeCycles, 4'h2);
`endif

    clr();
    step("tail", 0, 4'b1000);
    @(negedge clk);
    #5;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
